instr_decode: RTL
=================

// Module: instr_decode
// PURPOSE
// - Instruction-decode stage, directly upstream of REG_FILE and downstream of fetch.
// - Accepts one 32-bit RV32I instruction and its PC, and drives rs1/rs2 indices into REG_FILE.
// - Captures the operands one cycle later and builds the sign-extended immediate.
// - Presents a decoded bundle to execute under a valid/ready handshake, with write-back forwarding while stalled.
// PARAMETERS
// - LEN   32  datapath / register width
// - ADDR  32  PC width
// PORTS
// - clk           in   1     clock; single clock domain
// - rst           in   1     synchronous, active-high reset
// - rdy_in        in   1     global enable; when 0, all state and outputs freeze
// - flush         in   1     branch redirect; drops in-flight instruction
// - inst_valid    in   1     fetch has an instruction
// - inst          in   32    instruction word
// - inst_pc       in   ADDR  PC of inst
// - inst_ready    out  1     decode accepts inst this cycle
// - rf_rs1        out  5     REG_FILE rs1 index
// - rf_rs2        out  5     REG_FILE rs2 index
// - rf_rs1_data   in   LEN   REG_FILE rs1 data (valid the cycle after the index is presented)
// - rf_rs2_data   in   LEN   REG_FILE rs2 data
// - wb_en         in   1     write-back is writing this cycle
// - wb_rd         in   5     write-back destination
// - wb_data       in   LEN   write-back value
// - id_valid      out  1     decoded bundle valid
// - id_ready      in   1     execute accepts bundle
// - id_opcode     out  7     inst[6:0]
// - id_funct3     out  3     inst[14:12]
// - id_funct7     out  7     inst[31:25]
// - id_rd         out  5     destination index; 0 for S/B types
// - id_rs1_val    out  LEN   operand 1
// - id_rs2_val    out  LEN   operand 2
// - id_imm        out  LEN   sign-extended immediate
// - id_pc         out  ADDR  PC of the bundle
// BEHAVIOUR
// - States: IDLE -> READ -> HOLD.
//   - IDLE: inst_ready=1 (unless flush). On inst_valid, latch inst/pc, drive rf_rs1/rf_rs2 = inst[19:15]/inst[24:20], go to READ.
//   - READ: operands arrive from REG_FILE. Capture them into id_rs*_val, compute imm, set id_valid=1, go to HOLD.
//   - HOLD: on id_valid & id_ready, go to IDLE and clear id_valid.
// - Latency: accept -> id_valid in 2 cycles. Throughput: at most 1 instruction per 3 cycles.
// - Forwarding:
//   - In READ, if wb_en and wb_rd==rs and rs!=0, the operand takes wb_data.
//   - In HOLD, the same rule updates the held operand.
//   - Register x0 always reads 0, regardless of REG_FILE or wb.
// - Immediate: selected by opcode (I: LOAD/OP-IMM/JALR; S; B; U: LUI/AUIPC; J: JAL). Sign bit is inst[31]. Unknown opcode gives imm=0.
// - Flush:
//   - Has priority over everything except rst.
//   - Next state is IDLE and id_valid=0 next cycle.
//   - inst_ready=0 during the flush cycle, so a coincident inst is not accepted.
// - rdy_in=0: hold state; inst_ready=0; id_valid holds its value; wb forwarding is suspended.
// - Reset (also mid-operation): state IDLE, id_valid=0, all bundle registers 0, rf_rs1=rf_rs2=0. inst_ready=1 the cycle after reset deasserts.
// - Handshake rules:
//   - Bundle outputs are stable while id_valid=1 and id_ready=0, except for forwarded operands.
//   - id_valid never drops without id_ready or flush.
// STRUCTURE
// - defines.v:
//   - Opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG).
//   - IMM_I/S/B/U/J type codes.
//   - ID_IDLE/ID_READ/ID_HOLD state encodings.
// - Sub-module imm_gen: combinational; takes inst, returns the LEN-bit immediate.
// - Everything else (FSM, operand capture, forwarding mux) stays in instr_decode.
// TESTING
// - Latency and immediate: x1=10, inst 0xFFD08293 (addi x5,x1,-3).
//   Expect id_valid 2 cycles after accept; id_rd=5, id_rs1_val=10, id_imm=0xFFFFFFFD.
// - U-type: inst 0x123451B7 (lui x3,0x12345) -> id_imm=0x12345000, id_rd=3.
// - S-type: inst 0x0020A223 (sw x2,4(x1)) -> id_imm=4, id_rd=0, rf_rs2=2.
// - Backpressure forwarding: id_ready=0 for 3 cycles in HOLD; wb writes x1=99.
//   Expect id_rs1_val=99 the next cycle and inst_ready=0 throughout.
// - x0: rs1=0 with wb_en=1, wb_rd=0, wb_data=0xDEAD -> id_rs1_val stays 0.
// - Flush in READ with inst_valid=1 -> no id_valid, inst_ready=0 that cycle, IDLE next cycle.
//   Repeat with rst asserted mid-HOLD -> all outputs 0.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// Shared definitions for the instruction-decode stage.
// Contents:
//   - RV32I base opcodes used by the decoder
//   - immediate-format codes (imm_type_e) and the opcode -> format map
//   - decode FSM state encoding (id_state_e)
//   - has_rd(): whether an opcode writes a destination register
package instr_decode_pkg;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StHold
    } id_state_e;

    function automatic imm_type_e imm_type(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            OpLoad, OpImm, OpJalr: t = ImmI;
            OpStore:               t = ImmS;
            OpBranch:              t = ImmB;
            OpLui, OpAuipc:        t = ImmU;
            OpJal:                 t = ImmJ;
            OpReg:                 t = ImmNone;
            default:               t = ImmNone;
        endcase
        return t;
    endfunction

    // S and B formats reuse inst[11:7] as immediate bits, not a destination.
    function automatic logic has_rd(input logic [6:0] opcode);
        return (opcode != OpStore) && (opcode != OpBranch);
    endfunction

endpackage

// File: rtl/instr_decode_imm_gen.sv
// Combinational immediate generator.
// Ports:
//   inst_i  32-bit RV32I instruction word
//   imm_o   Len-bit sign-extended immediate (0 for formats without one)
module instr_decode_imm_gen
    import instr_decode_pkg::*;
#(
    parameter int unsigned Len = 32
) (
    input  logic [31:0]    inst_i,
    output logic [Len-1:0] imm_o
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_type(inst_i[6:0]))
            ImmI: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            ImmS: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            ImmB: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                           inst_i[11:8], 1'b0};
            ImmU: imm32 = {inst_i[31:12], 12'b0};
            ImmJ: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                           inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Signed source, so a wider Len sign-extends from bit 31.
        imm_o = Len'(imm32);
    end

endmodule

// File: rtl/instr_decode.sv
// Instruction-decode stage between fetch and execute.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   rdy_in_i                          global enable; 0 freezes all state
//   flush_i                           branch redirect; drops the in-flight instruction
//   inst_valid_i/inst_i/inst_pc_i     fetch side; inst_ready_o accepts
//   rf_rs1_o/rf_rs2_o                 REG_FILE read indices
//   rf_rs1_data_i/rf_rs2_data_i       REG_FILE data, one cycle after the index
//   wb_en_i/wb_rd_i/wb_data_i         write-back port, forwarded into operands
//   id_valid_o/id_ready_i             execute-side handshake
//   id_opcode_o .. id_pc_o            decoded bundle
module instr_decode
    import instr_decode_pkg::*;
#(
    parameter int unsigned Len  = 32,
    parameter int unsigned Addr = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rdy_in_i,
    input  logic            flush_i,
    input  logic            inst_valid_i,
    input  logic [31:0]     inst_i,
    input  logic [Addr-1:0] inst_pc_i,
    output logic            inst_ready_o,
    output logic [4:0]      rf_rs1_o,
    output logic [4:0]      rf_rs2_o,
    input  logic [Len-1:0]  rf_rs1_data_i,
    input  logic [Len-1:0]  rf_rs2_data_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [Len-1:0]  wb_data_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [6:0]      id_opcode_o,
    output logic [2:0]      id_funct3_o,
    output logic [6:0]      id_funct7_o,
    output logic [4:0]      id_rd_o,
    output logic [Len-1:0]  id_rs1_val_o,
    output logic [Len-1:0]  id_rs2_val_o,
    output logic [Len-1:0]  id_imm_o,
    output logic [Addr-1:0] id_pc_o
);

    id_state_e       state_q, state_d;
    logic [31:0]     inst_q, inst_d;
    logic [Addr-1:0] pc_q, pc_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [Len-1:0]  rs1_val_q, rs1_val_d;
    logic [Len-1:0]  rs2_val_q, rs2_val_d;
    logic [Len-1:0]  imm_q, imm_d;
    logic [Len-1:0]  imm_next;
    logic            accept;

    // x0 is hard-wired to zero; otherwise a matching write-back wins over the base value.
    function automatic logic [Len-1:0] fwd_operand(input logic [4:0]     idx,
                                                   input logic [Len-1:0] base,
                                                   input logic           wb_en,
                                                   input logic [4:0]     wb_rd,
                                                   input logic [Len-1:0] wb_data);
        if (idx == 5'd0) begin
            return '0;
        end
        if (wb_en && (wb_rd == idx)) begin
            return wb_data;
        end
        return base;
    endfunction

    instr_decode_imm_gen #(
        .Len (Len)
    ) u_imm_gen (
        .inst_i (inst_q),
        .imm_o  (imm_next)
    );

    assign inst_ready_o = (state_q == StIdle) && rdy_in_i && !flush_i && !rst_i;
    assign accept       = inst_ready_o && inst_valid_i;

    // The index goes out combinationally on accept so the synchronous REG_FILE
    // returns data in READ; afterwards the latched index is held.
    assign rf_rs1_o = accept ? inst_i[19:15] : rs1_q;
    assign rf_rs2_o = accept ? inst_i[24:20] : rs2_q;

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        pc_d      = pc_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        imm_d     = imm_q;

        if (flush_i) begin
            state_d = StIdle;
        end else if (rdy_in_i) begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        inst_d  = inst_i;
                        pc_d    = inst_pc_i;
                        rs1_d   = inst_i[19:15];
                        rs2_d   = inst_i[24:20];
                        state_d = StRead;
                    end
                end
                StRead: begin
                    rs1_val_d = fwd_operand(rs1_q, rf_rs1_data_i, wb_en_i, wb_rd_i, wb_data_i);
                    rs2_val_d = fwd_operand(rs2_q, rf_rs2_data_i, wb_en_i, wb_rd_i, wb_data_i);
                    imm_d     = imm_next;
                    state_d   = StHold;
                end
                StHold: begin
                    rs1_val_d = fwd_operand(rs1_q, rs1_val_q, wb_en_i, wb_rd_i, wb_data_i);
                    rs2_val_d = fwd_operand(rs2_q, rs2_val_q, wb_en_i, wb_rd_i, wb_data_i);
                    if (id_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            inst_q    <= '0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            imm_q     <= imm_d;
        end
    end

    assign id_valid_o   = (state_q == StHold);
    assign id_opcode_o  = inst_q[6:0];
    assign id_funct3_o  = inst_q[14:12];
    assign id_funct7_o  = inst_q[31:25];
    assign id_rd_o      = has_rd(inst_q[6:0]) ? inst_q[11:7] : 5'd0;
    assign id_rs1_val_o = rs1_val_q;
    assign id_rs2_val_o = rs2_val_q;
    assign id_imm_o     = imm_q;
    assign id_pc_o      = pc_q;

endmodule
